// File: rtl/cpu_ctrl_pkg.sv
// Shared control-flow definitions: PC-mux select codes and branch-resolve FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  // PC-mux select encodings
  localparam logic [1:0] PCSEL_MEM = 2'b00;  // memory-indirect target
  localparam logic [1:0] PCSEL_REL = 2'b01;  // PC-relative branch target
  localparam logic [1:0] PCSEL_SEQ = 2'b10;  // sequential PC+4
  localparam logic [1:0] PCSEL_JMP = 2'b11;  // absolute jump target

  // Width of the squash-window down-counter (FLUSH_CYCLES <= 15)
  localparam int FCNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } brs_state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition and PC-select priority resolution from decoded op bits and effective flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports:
//   op_beq/op_balrn/op_blez/op_jal/op_jmor : decoded op bits
//   z, n  : effective zero/negative flags (already forwarded by the caller)
//   sel   : PC-mux select, priority jal > beq/blez > balrn/jmor > sequential
//   take  : sel is not sequential (a redirect)
//   link  : link-register write request (jal or taken balrn)
module br_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic       op_beq,
  input  logic       op_balrn,
  input  logic       op_blez,
  input  logic       op_jal,
  input  logic       op_jmor,
  input  logic       z,
  input  logic       n,
  output logic [1:0] sel,
  output logic       take,
  output logic       link
);

  logic beq_t;
  logic blez_t;
  logic balrn_t;

  assign beq_t   = z & op_beq;
  assign blez_t  = (z | n) & op_blez;
  assign balrn_t = n & op_balrn;

  always_comb begin
    sel = PCSEL_SEQ;
    if (op_jal) begin
      sel = PCSEL_JMP;
    end else if (beq_t || blez_t) begin
      sel = PCSEL_REL;
    end else if (balrn_t || op_jmor) begin
      sel = PCSEL_MEM;
    end
  end

  assign take = (sel != PCSEL_SEQ);

  // Link follows jal/balrn even when a higher-priority select wins.
  assign link = op_jal | balrn_t;

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution: flag latch, PC-select, link write, squash window, redirect count.
// Latency: one cycle from an evaluated br_valid to pc_sel/redirect/link_we/flush.
// Backpressure: stall freezes evaluation and the squash counter; flag updates are never blocked.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   stall             : freeze evaluation / FSM
//   br_valid, op_*    : decoded control-flow instruction
//   flag_we, alu_z/n  : ALU flag update (also forwarded into a same-cycle evaluation)
//   pc_plus4          : PC+4 of the qualified instruction (link value)
//   pc_sel, redirect  : registered PC-mux select and one-cycle redirect pulse
//   flush             : squash window, FLUSH_CYCLES unstalled cycles after a redirect
//   link_we, link_addr: registered link-register write
//   taken_cnt         : saturating redirect counter
module branch_resolve_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             op_beq,
  input  logic             op_balrn,
  input  logic             op_blez,
  input  logic             op_jal,
  input  logic             op_jmor,
  input  logic             flag_we,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic [PC_W-1:0]  pc_plus4,
  output logic [1:0]       pc_sel,
  output logic             redirect,
  output logic             flush,
  output logic             link_we,
  output logic [PC_W-1:0]  link_addr,
  output logic [CNT_W-1:0] taken_cnt
);

  logic z_q;
  logic n_q;
  logic eff_z;
  logic eff_n;

  logic [1:0] ev_sel;
  logic       ev_take;
  logic       ev_link;

  brs_state_t        state, state_n;
  logic [FCNT_W-1:0] fcnt, fcnt_n;
  logic [1:0]        pc_sel_n;
  logic              redirect_n;
  logic              flush_n;
  logic              link_we_n;
  logic [PC_W-1:0]   link_addr_n;
  logic [CNT_W-1:0]  taken_cnt_n;

  // Flags update independently of stall and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (flag_we) begin
      z_q <= alu_z;
      n_q <= alu_n;
    end
  end

  // Forward a same-cycle flag update into the evaluation.
  assign eff_z = flag_we ? alu_z : z_q;
  assign eff_n = flag_we ? alu_n : n_q;

  br_cond_eval u_cond (
    .op_beq   (op_beq),
    .op_balrn (op_balrn),
    .op_blez  (op_blez),
    .op_jal   (op_jal),
    .op_jmor  (op_jmor),
    .z        (eff_z),
    .n        (eff_n),
    .sel      (ev_sel),
    .take     (ev_take),
    .link     (ev_link)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      fcnt      <= '0;
      pc_sel    <= PCSEL_SEQ;
      redirect  <= 1'b0;
      flush     <= 1'b0;
      link_we   <= 1'b0;
      link_addr <= '0;
      taken_cnt <= '0;
    end else begin
      state     <= state_n;
      fcnt      <= fcnt_n;
      pc_sel    <= pc_sel_n;
      redirect  <= redirect_n;
      flush     <= flush_n;
      link_we   <= link_we_n;
      link_addr <= link_addr_n;
      taken_cnt <= taken_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    fcnt_n      = fcnt;
    pc_sel_n    = pc_sel;
    redirect_n  = 1'b0;
    flush_n     = flush;
    link_we_n   = 1'b0;
    link_addr_n = link_addr;
    taken_cnt_n = taken_cnt;

    case (state)
      ST_IDLE: begin
        if (br_valid && !stall) begin
          pc_sel_n   = ev_sel;
          redirect_n = ev_take;
          link_we_n  = ev_link;
          if (ev_link) begin
            link_addr_n = pc_plus4;
          end
          if (ev_take) begin
            if (taken_cnt != {CNT_W{1'b1}}) begin
              taken_cnt_n = taken_cnt + CNT_W'(1);
            end
            state_n = ST_FLUSH;
            fcnt_n  = FCNT_W'(FLUSH_CYCLES);
            flush_n = 1'b1;
          end
        end else if (!stall) begin
          pc_sel_n = PCSEL_SEQ;
        end
      end

      ST_FLUSH: begin
        // br_valid is ignored here: the instruction is squashed upstream.
        pc_sel_n = PCSEL_SEQ;
        flush_n  = 1'b1;
        if (!stall) begin
          if (fcnt == FCNT_W'(1)) begin
            fcnt_n  = '0;
            flush_n = 1'b0;
            state_n = ST_IDLE;
          end else begin
            fcnt_n = fcnt - FCNT_W'(1);
          end
        end
      end

      default: begin
        state_n  = ST_IDLE;
        fcnt_n   = '0;
        flush_n  = 1'b0;
        pc_sel_n = PCSEL_SEQ;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: per-cycle vector table plus a counter-saturation sequence.
// Latency: each vector's expected outputs are those seen one edge after its inputs.
// Backpressure: stall is exercised both in IDLE and mid-squash.
module tb_branch_resolve_unit;

  localparam int PC_W = 32;
  localparam int CNT_W = 2;

  localparam logic [4:0] O_NONE  = 5'b00000;
  localparam logic [4:0] O_JAL   = 5'b10000;
  localparam logic [4:0] O_BEQ   = 5'b01000;
  localparam logic [4:0] O_BLEZ  = 5'b00100;
  localparam logic [4:0] O_BALRN = 5'b00010;
  localparam logic [4:0] O_JMOR  = 5'b00001;

  logic             clk = 1'b0;
  logic             reset, stall, br_valid;
  logic             op_beq, op_balrn, op_blez, op_jal, op_jmor;
  logic             flag_we, alu_z, alu_n;
  logic [PC_W-1:0]  pc_plus4;
  logic [1:0]       pc_sel;
  logic             redirect, flush, link_we;
  logic [PC_W-1:0]  link_addr;
  logic [CNT_W-1:0] taken_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .PC_W(PC_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .op_beq(op_beq), .op_balrn(op_balrn), .op_blez(op_blez),
    .op_jal(op_jal), .op_jmor(op_jmor),
    .flag_we(flag_we), .alu_z(alu_z), .alu_n(alu_n), .pc_plus4(pc_plus4),
    .pc_sel(pc_sel), .redirect(redirect), .flush(flush), .link_we(link_we),
    .link_addr(link_addr), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic        rst, stl, bv;
    logic [4:0]  ops;
    logic        fwe, z, n;
    logic [31:0] pc4;
    logic [1:0]  e_sel;
    logic        e_red, e_fl, e_lwe;
    logic [31:0] e_la;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t vt [NV];

  function automatic vec_t v(input logic rst, input logic stl, input logic bv, input logic [4:0] ops,
                             input logic fwe, input logic z, input logic n, input logic [31:0] pc4,
                             input logic [1:0] e_sel, input logic e_red, input logic e_fl,
                             input logic e_lwe, input logic [31:0] e_la, input logic [1:0] e_cnt);
    vec_t r;
    r.rst = rst; r.stl = stl; r.bv = bv; r.ops = ops; r.fwe = fwe; r.z = z; r.n = n; r.pc4 = pc4;
    r.e_sel = e_sel; r.e_red = e_red; r.e_fl = e_fl; r.e_lwe = e_lwe; r.e_la = e_la; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got 0x%0h want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic bv, input logic [4:0] ops,
                       input logic fwe, input logic z, input logic n, input logic [31:0] pc4);
    reset = rst; stall = stl; br_valid = bv;
    {op_jal, op_beq, op_blez, op_balrn, op_jmor} = ops;
    flag_we = fwe; alu_z = z; alu_n = n; pc_plus4 = pc4;
  endtask

  logic [1:0] sat_exp [4];
  int         waited;

  initial begin
    drive(1'b1, 1'b0, 1'b0, O_NONE, 1'b0, 1'b0, 1'b0, 32'h0);

    //          rst stl bv ops           fwe z  n  pc4            sel red fl lwe la            cnt
    vt[0]  = v(1, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 0, 0, 32'h0,        0);
    vt[1]  = v(0, 0, 1, O_BEQ,         1, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        1);
    vt[2]  = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 1, 0, 32'h0,        1);
    vt[3]  = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 0, 0, 32'h0,        1);
    vt[4]  = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 0, 0, 32'h0,        1);
    vt[5]  = v(0, 0, 0, O_NONE,        1, 0, 1, 32'h0,        2, 0, 0, 0, 32'h0,        1);
    vt[6]  = v(0, 0, 1, O_BLEZ,        0, 0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        2);
    vt[7]  = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 1, 0, 32'h0,        2);
    vt[8]  = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 0, 0, 32'h0,        2);
    vt[9]  = v(0, 0, 1, O_BEQ,         0, 1, 0, 32'h0,        2, 0, 0, 0, 32'h0,        2);
    vt[10] = v(0, 0, 1, O_JAL | O_BEQ, 1, 1, 0, 32'h00400010, 3, 1, 1, 1, 32'h00400010, 3);
    vt[11] = v(0, 0, 1, O_BEQ,         0, 0, 0, 32'h0,        2, 0, 1, 0, 32'h00400010, 3);
    vt[12] = v(0, 1, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 1, 0, 32'h00400010, 3);
    vt[13] = v(0, 1, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 1, 0, 32'h00400010, 3);
    vt[14] = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 0, 0, 32'h00400010, 3);
    vt[15] = v(0, 0, 1, O_BEQ,         0, 0, 0, 32'h0,        1, 1, 1, 0, 32'h00400010, 3);
    vt[16] = v(1, 0, 1, O_JAL,         0, 0, 0, 32'h5555,     2, 0, 0, 0, 32'h0,        0);
    vt[17] = v(0, 0, 1, O_JMOR,        0, 0, 0, 32'h0,        0, 1, 1, 0, 32'h0,        1);
    vt[18] = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 1, 0, 32'h0,        1);
    vt[19] = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 0, 0, 32'h0,        1);
    vt[20] = v(0, 0, 1, O_BALRN,       1, 0, 1, 32'h1000,     0, 1, 1, 1, 32'h1000,     2);
    vt[21] = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 1, 0, 32'h1000,     2);
    vt[22] = v(0, 1, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 1, 0, 32'h1000,     2);
    vt[23] = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 0, 0, 32'h1000,     2);
    vt[24] = v(0, 1, 1, O_JAL,         0, 0, 0, 32'h2000,     2, 0, 0, 0, 32'h1000,     2);
    vt[25] = v(0, 0, 1, O_NONE,        0, 0, 0, 32'h0,        2, 0, 0, 0, 32'h1000,     2);
    vt[26] = v(0, 0, 1, O_BEQ|O_BALRN, 1, 1, 1, 32'h3000,     1, 1, 1, 1, 32'h3000,     3);
    vt[27] = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 1, 0, 32'h3000,     3);
    vt[28] = v(0, 0, 0, O_NONE,        0, 0, 0, 32'h0,        2, 0, 0, 0, 32'h3000,     3);
    vt[29] = v(0, 0, 1, O_BLEZ,        1, 0, 0, 32'h0,        2, 0, 0, 0, 32'h3000,     3);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].stl, vt[i].bv, vt[i].ops, vt[i].fwe, vt[i].z, vt[i].n, vt[i].pc4);
      @(posedge clk);
      #1;
      check("pc_sel",    i, 32'(pc_sel),    32'(vt[i].e_sel));
      check("redirect",  i, 32'(redirect),  32'(vt[i].e_red));
      check("flush",     i, 32'(flush),     32'(vt[i].e_fl));
      check("link_we",   i, 32'(link_we),   32'(vt[i].e_lwe));
      check("link_addr", i, link_addr,      vt[i].e_la);
      check("taken_cnt", i, 32'(taken_cnt), 32'(vt[i].e_cnt));
    end

    // Counter saturation: four jmor redirects from reset give 1, 2, 3, 3.
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3;
    drive(1'b1, 1'b0, 1'b0, O_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("sat_reset_cnt", 100, 32'(taken_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1, O_JMOR, 1'b0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      check("sat_redirect", 100 + k, 32'(redirect),  32'd1);
      check("sat_cnt",      100 + k, 32'(taken_cnt), 32'(sat_exp[k]));
      drive(1'b0, 1'b0, 1'b0, O_NONE, 1'b0, 1'b0, 1'b0, 32'h0);
      waited = 0;
      while (flush && waited < 20) begin
        @(posedge clk);
        #1;
        waited++;
      end
      check("sat_flush_drop", 100 + k, 32'(flush), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Registered, parametrised successor to the combinational jump/branch control. It latches ALU Z/N status flags, resolves beq/blez/balrn/jal/jmor into a registered 2-bit PC-select, and generates a link-register write for jal/balrn. After every taken redirect it runs a squash window of FLUSH_CYCLES cycles and keeps a saturating count of taken redirects. It sits between decode/ALU and the PC mux.

Parameters:
PC_W, 32, width of pc_plus4 and link_addr
FLUSH_CYCLES, 2, cycles flush is held after a redirect (legal range 1..15)
CNT_W, 16, width of the taken-redirect counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
stall  in  1  freezes branch evaluation and the FSM; does not block flag updates
br_valid  in  1  decoded control-flow instruction present this cycle
op_beq, op_balrn, op_blez, op_jal, op_jmor  in  1 each  decoded op bits
flag_we  in  1  ALU flag update strobe
alu_z, alu_n  in  1 each  ALU zero/negative results
pc_plus4  in  PC_W  PC+4 of the instruction qualified by br_valid
pc_sel  out  2  registered PC-mux select: 00 mem-indirect, 01 relative, 10 sequential, 11 absolute jump
redirect  out  1  one-cycle pulse, registered; pc_sel != 10 was just resolved
flush  out  1  high for exactly FLUSH_CYCLES cycles after redirect
link_we  out  1  one-cycle pulse, registered link-register write
link_addr  out  PC_W  value to write (captured pc_plus4)
taken_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- Reset values: pc_sel=10, redirect=0, flush=0, link_we=0, link_addr=0, taken_cnt=0, z_q=n_q=0, FSM=IDLE, flush counter=0. Reset overrides all other inputs, including in FLUSH.
- Flag register: on flag_we, z_q<=alu_z and n_q<=alu_n, regardless of stall or FSM state.
- Effective flags: when flag_we=1 in the same cycle as an evaluation, use alu_z/alu_n (forwarding). Otherwise use z_q/n_q.
- Conditions: beq_t=Z&op_beq; blez_t=(Z|N)&op_blez; balrn_t=N&op_balrn.
- Select priority, highest first:
  - op_jal gives 11.
  - beq_t or blez_t gives 01.
  - balrn_t or op_jmor gives 00.
  - Otherwise 10.
- FSM IDLE, evaluation when br_valid & !stall, with all outputs registered (1-cycle latency):
  - pc_sel <= computed select.
  - redirect <= (select != 10).
  - link_we <= op_jal | balrn_t; link_addr <= pc_plus4 when link_we is set, otherwise held.
  - If redirect: taken_cnt increments, saturating at all-ones. FSM moves to FLUSH with counter=FLUSH_CYCLES and flush<=1 on the same edge.
- IDLE without evaluation (br_valid=0, or stall=1):
  - redirect=0 and link_we=0.
  - pc_sel <= 10 when !stall; pc_sel holds when stall.
- FSM FLUSH:
  - flush=1 throughout; br_valid is ignored (instructions squashed upstream); redirect=0, link_we=0, pc_sel=10.
  - The counter decrements each non-stalled cycle. When it goes 1->0, flush<=0 and the FSM returns to IDLE.
  - stall freezes the counter and holds flush=1.
  - flush is therefore high for exactly FLUSH_CYCLES unstalled cycles.
- br_valid with no op bit set: pc_sel=10, no redirect, no link.
- Multiple op bits set: the priority order above applies. link_we uses the OR of jal and balrn_t, even when the select goes elsewhere.
- A back-to-back branch in the first IDLE cycle after FLUSH is evaluated normally.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - PC-select constants PCSEL_MEM=2'b00, PCSEL_REL=2'b01, PCSEL_SEQ=2'b10, PCSEL_JMP=2'b11.
  - FSM state encodings ST_IDLE and ST_FLUSH.
- One combinational sub-module, br_cond_eval:
  - Inputs: op bits and effective Z/N.
  - Outputs: 2-bit select, take, link.
  - Priority and condition logic are isolated there; the top level holds the flags, FSM, counters and output registers.

Test Plan:
- Reset, then beq with alu_z=1 and flag_we=1 in the same cycle: next cycle pc_sel=01 and redirect=1. Then flush=1 for 2 cycles, followed by flush=0 and taken_cnt=1.
- flag_we with z=0 and n=1, then blez with flag_we=0: pc_sel=01 using the latched flags. A following beq with flags unchanged gives pc_sel=10, redirect=0.
- jal with pc_plus4=0x00400010 and op_beq also set, flags Z=1: pc_sel=11, link_we=1, link_addr=0x00400010.
- Branch presented during FLUSH: ignored, pc_sel stays 10. A stall raised mid-FLUSH extends flush by the number of stalled cycles.
- reset asserted during FLUSH: next cycle flush=0, pc_sel=10, taken_cnt=0. A jmor issued right after gives pc_sel=00.
- With CNT_W=2, four redirects: taken_cnt goes 1, 2, 3, 3 (saturates).
